// File: rtl/cpaf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpaf_pkg: shared widths, saturation bounds and FIFO entry type       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpaf_pkg;

    localparam int C_W      = 71;
    localparam int SUM_W    = 36;
    localparam int CARRY_W  = 35;
    localparam int SPLIT    = 18;
    localparam int OUT_W    = 8;
    localparam int HI_W     = SUM_W - SPLIT;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef struct packed {
        logic             propagate;
        logic [OUT_W-1:0] data;
    } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/cpaf_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpaf_sync_fifo: registered-output synchronous FIFO, no fall-through  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpaf_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        pop_ok   = i_pop && (count_q != '0);
        // A full FIFO still takes a push when the head leaves in the same cycle
        push_ok  = i_push && ((count_q != FULL_CNT) || pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_wdata;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_rdata = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cpaf_result_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpaf_result_resolver: carry-save resolve, round-shift, int8 saturate |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cpaf_result_resolver
    import cpaf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [C_W-1:0]         io_in_c,
    input  logic                   io_in_valid,
    input  logic [4:0]             io_in_control_shift,
    input  logic                   io_in_control_propagate,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_propagate,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow_err
);

    localparam int                    ENT_W   = $bits(result_entry_t);
    localparam logic signed [SUM_W:0] SAT_MAX = (SUM_W+1)'(INT8_MAX);
    localparam logic signed [SUM_W:0] SAT_MIN = (SUM_W+1)'(INT8_MIN);

    logic [SUM_W-1:0]   sum_in;
    logic [CARRY_W-1:0] carry_in;
    logic [SPLIT:0]     lo_sum;
    logic [HI_W-1:0]    hi_sum;

    logic               s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0]   s1_lo_q, s1_lo_d;
    logic               s1_cout_q, s1_cout_d;
    logic [HI_W-1:0]    s1_sum_hi_q, s1_sum_hi_d;
    logic [HI_W-1:0]    s1_carry_hi_q, s1_carry_hi_d;
    logic [4:0]         s1_shift_q, s1_shift_d;
    logic               s1_prop_q, s1_prop_d;

    logic               s2_valid_q, s2_valid_d;
    logic [SUM_W-1:0]   s2_r_q, s2_r_d;
    logic [4:0]         s2_shift_q, s2_shift_d;
    logic               s2_prop_q, s2_prop_d;

    logic signed [SUM_W:0] r_ext, bias, rounded, t_val;

    logic               s3_valid_q, s3_valid_d;
    result_entry_t      s3_entry_q, s3_entry_d;
    logic               overflow_q, overflow_d;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [ENT_W-1:0]   fifo_rdata;
    result_entry_t      head;

    assign sum_in   = io_in_c[SUM_W-1:0];
    assign carry_in = io_in_c[C_W-1:SUM_W];

    always_comb begin
        lo_sum        = {1'b0, sum_in[SPLIT-1:0]} + {1'b0, carry_in[SPLIT-1:0]};
        s1_valid_d    = io_in_valid;
        s1_lo_d       = lo_sum[SPLIT-1:0];
        s1_cout_d     = lo_sum[SPLIT];
        s1_sum_hi_d   = sum_in[SUM_W-1:SPLIT];
        s1_carry_hi_d = {carry_in[CARRY_W-1], carry_in[CARRY_W-1:SPLIT]};
        s1_shift_d    = io_in_control_shift;
        s1_prop_d     = io_in_control_propagate;

        hi_sum        = s1_sum_hi_q + s1_carry_hi_q + HI_W'(s1_cout_q);
        s2_valid_d    = s1_valid_q;
        s2_r_d        = {hi_sum, s1_lo_q};
        s2_shift_d    = s1_shift_q;
        s2_prop_d     = s1_prop_q;

        // One guard bit above R keeps the half-LSB bias from overflowing
        r_ext   = {s2_r_q[SUM_W-1], s2_r_q};
        bias    = (s2_shift_q == 5'd0) ? '0
                : ((SUM_W+1)'(1) << (s2_shift_q - 5'd1));
        rounded = r_ext + bias;
        t_val   = rounded >>> s2_shift_q;

        s3_valid_d           = s2_valid_q;
        s3_entry_d.propagate = s2_prop_q;
        if (t_val > SAT_MAX) begin
            s3_entry_d.data = OUT_W'(INT8_MAX);
        end else if (t_val < SAT_MIN) begin
            s3_entry_d.data = OUT_W'(INT8_MIN);
        end else begin
            s3_entry_d.data = t_val[OUT_W-1:0];
        end

        overflow_d = overflow_q | (s3_valid_q & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1_valid_q    <= 1'b0;
            s1_lo_q       <= '0;
            s1_cout_q     <= 1'b0;
            s1_sum_hi_q   <= '0;
            s1_carry_hi_q <= '0;
            s1_shift_q    <= '0;
            s1_prop_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_r_q        <= '0;
            s2_shift_q    <= '0;
            s2_prop_q     <= 1'b0;
            s3_valid_q    <= 1'b0;
            s3_entry_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_lo_q       <= s1_lo_d;
            s1_cout_q     <= s1_cout_d;
            s1_sum_hi_q   <= s1_sum_hi_d;
            s1_carry_hi_q <= s1_carry_hi_d;
            s1_shift_q    <= s1_shift_d;
            s1_prop_q     <= s1_prop_d;
            s2_valid_q    <= s2_valid_d;
            s2_r_q        <= s2_r_d;
            s2_shift_q    <= s2_shift_d;
            s2_prop_q     <= s2_prop_d;
            s3_valid_q    <= s3_valid_d;
            s3_entry_q    <= s3_entry_d;
            overflow_q    <= overflow_d;
        end
    end

    assign fifo_pop = ~fifo_empty & out_ready;

    cpaf_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (s3_valid_q),
        .i_wdata (s3_entry_q),
        .i_pop   (fifo_pop),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign head          = result_entry_t'(fifo_rdata);
    assign out_data      = head.data;
    assign out_propagate = head.propagate;
    assign out_valid     = ~fifo_empty;
    assign overflow_err  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cpaf_result_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpaf_result_resolver: directed and random checks vs queue model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cpaf_result_resolver;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [70:0] io_in_c = '0;
    logic        io_in_valid = 1'b0;
    logic [4:0]  io_in_control_shift = '0;
    logic        io_in_control_propagate = 1'b0;
    logic [7:0]  out_data;
    logic        out_propagate;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         v;
        bit         p;
        logic [7:0] d;
    } ent_t;

    ent_t dl[$];
    ent_t mq[$];
    bit   ovf;

    cpaf_result_resolver dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .io_in_c                 (io_in_c),
        .io_in_valid             (io_in_valid),
        .io_in_control_shift     (io_in_control_shift),
        .io_in_control_propagate (io_in_control_propagate),
        .out_data                (out_data),
        .out_propagate           (out_propagate),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .fifo_count              (fifo_count),
        .overflow_err            (overflow_err)
    );

    always #5 CLK = ~CLK;

    // Resolved value, rounded shift and int8 clamp using plain integer math
    function automatic logic [7:0] ref_result(longint s, longint c, int sh);
        longint r, t;
        r = s + c;
        if (r >= (longint'(1) <<< 35))       r = r - (longint'(1) <<< 36);
        else if (r < -(longint'(1) <<< 35))  r = r + (longint'(1) <<< 36);
        t = (sh == 0) ? r : ((r + (longint'(1) <<< (sh - 1))) >>> sh);
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return 8'(t);
    endfunction

    task automatic reset_model();
        ent_t z;
        z.v = 1'b0; z.p = 1'b0; z.d = '0;
        mq.delete();
        dl.delete();
        repeat (3) dl.push_back(z);
        ovf = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the clock edge, return at negedge
    task automatic step(bit v, longint s, longint c, int sh, bit p, bit rdy, bit rst_n);
        ent_t e, n;
        bit   pop;
        RST                     = rst_n;
        io_in_valid             = v;
        io_in_c                 = {35'(c), 36'(s)};
        io_in_control_shift     = 5'(sh);
        io_in_control_propagate = p;
        out_ready               = rdy;
        @(posedge CLK);
        if (!rst_n) begin
            reset_model();
        end else begin
            n.v = v; n.p = p; n.d = ref_result(s, c, sh);
            e   = dl.pop_front();
            dl.push_back(n);
            pop = (mq.size() > 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (e.v) begin
                if (mq.size() < 4) mq.push_back(e);
                else               ovf = 1'b1;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(bit rdy);
        step(1'b0, 0, 0, 0, 1'b0, rdy, 1'b1);
    endtask

    // One word in, then idle until it is the visible FIFO head
    task automatic send_and_wait(longint s, longint c, int sh, bit p);
        step(1'b1, s, c, sh, p, 1'b1, 1'b1);
        repeat (3) idle(1'b1);
    endtask

    task automatic test_reset();
        reset_model();
        repeat (2) step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({out_valid, fifo_count, overflow_err, out_data, out_propagate} !== 14'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%0b count=%0d ovf=%0b data=%0d prop=%0b, expected all 0",
                     out_valid, fifo_count, overflow_err, out_data, out_propagate);
        end
    endtask

    task automatic test_basic_latency();
        step(1'b1, 100, 20, 0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL latency_early[%0d]: out_valid=%0b expected 0", i, out_valid);
            end
            idle(1'b1);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd120) begin
            miscompares++;
            $display("FAIL latency_k3: valid=%0b data=%0d expected 1/120", out_valid, $signed(out_data));
        end
        idle(1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_pop: out_valid=%0b expected 0", out_valid);
        end
    endtask

    task automatic test_rounding();
        send_and_wait(-302, 0, 2, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hB5) begin
            miscompares++;
            $display("FAIL round_m302: valid=%0b data=%0d expected 1/-75", out_valid, $signed(out_data));
        end
        idle(1'b1);
        send_and_wait(-300, 0, 2, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hB5) begin
            miscompares++;
            $display("FAIL round_m300: valid=%0b data=%0d expected 1/-75", out_valid, $signed(out_data));
        end
        idle(1'b1);
    endtask

    task automatic test_saturation();
        send_and_wait(1000, 0, 0, 1'b1);
        vectors++;
        if ({out_valid, out_propagate, out_data} !== {1'b1, 1'b1, 8'h7F}) begin
            miscompares++;
            $display("FAIL sat_pos: valid=%0b prop=%0b data=%0d expected 1/1/127",
                     out_valid, out_propagate, $signed(out_data));
        end
        idle(1'b1);
        send_and_wait(-1000, 0, 0, 1'b1);
        vectors++;
        if ({out_valid, out_propagate, out_data} !== {1'b1, 1'b1, 8'h80}) begin
            miscompares++;
            $display("FAIL sat_neg: valid=%0b prop=%0b data=%0d expected 1/1/-128",
                     out_valid, out_propagate, $signed(out_data));
        end
        idle(1'b1);
    endtask

    task automatic test_carry_split();
        send_and_wait(64'h3FFFF, 1, 12, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'd64) begin
            miscompares++;
            $display("FAIL split_carry: valid=%0b data=%0d expected 1/64", out_valid, $signed(out_data));
        end
        idle(1'b1);
        send_and_wait(0, -1, 0, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
            miscompares++;
            $display("FAIL split_neg1: valid=%0b data=%0d expected 1/-1", out_valid, $signed(out_data));
        end
        idle(1'b1);
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 6; v++) step(1'b1, v, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        vectors++;
        if (fifo_count !== 3'd4 || overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_fill: count=%0d ovf=%0b expected 4/0", fifo_count, overflow_err);
        end
        idle(1'b0);
        vectors++;
        if (fifo_count !== 3'd4 || overflow_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: count=%0d ovf=%0b expected 4/1", fifo_count, overflow_err);
        end
        idle(1'b0);
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL ovf_drain[%0d]: valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, i);
            end
            idle(1'b1);
        end
        vectors++;
        if ({out_valid, fifo_count, overflow_err} !== {1'b0, 3'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_sticky: valid=%0b count=%0d ovf=%0b expected 0/0/1",
                     out_valid, fifo_count, overflow_err);
        end
    endtask

    task automatic test_reset_midstream();
        for (int v = 21; v <= 25; v++) step(1'b1, v, 0, 0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (fifo_count !== 3'd2) begin
            miscompares++;
            $display("FAIL mid_pre: count=%0d expected 2", fifo_count);
        end
        step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({out_valid, fifo_count, overflow_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%0b count=%0d ovf=%0b expected 0/0/0",
                     out_valid, fifo_count, overflow_err);
        end
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            vectors++;
            if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
                miscompares++;
                $display("FAIL mid_stale[%0d]: valid=%0b count=%0d data=%0d expected 0/0",
                         i, out_valid, fifo_count, out_data);
            end
        end
    endtask

    task automatic test_full_push_pop();
        for (int v = 11; v <= 15; v++) step(1'b1, v, 0, 0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        vectors++;
        if ({fifo_count, overflow_err, out_data} !== {3'd4, 1'b0, 8'd12}) begin
            miscompares++;
            $display("FAIL full_pushpop: count=%0d ovf=%0b head=%0d expected 4/0/12",
                     fifo_count, overflow_err, out_data);
        end
        for (int i = 12; i <= 15; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL full_drain[%0d]: valid=%0b data=%0d expected 1/%0d", i, out_valid, out_data, i);
            end
            idle(1'b1);
        end
    endtask

    function automatic longint rnd_val(int w);
        logic [63:0] raw;
        longint      x;
        if ($urandom_range(1, 0) == 1) return longint'($urandom_range(4000)) - 2000;
        raw = {$urandom(), $urandom()};
        x   = $signed(raw);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic test_random();
        step(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        for (int n = 0; n < 700; n++) begin
            if (n < 680) begin
                step($urandom_range(9) < 7, rnd_val(36), rnd_val(35),
                     ($urandom_range(3) == 0) ? int'($urandom_range(31)) : int'($urandom_range(4)),
                     1'($urandom_range(1)), $urandom_range(1) == 1, 1'b1);
            end else begin
                idle(1'b1);
            end
            vectors++;
            if ({out_valid, fifo_count, overflow_err} !== {mq.size() > 0, 3'(mq.size()), ovf}) begin
                miscompares++;
                $display("FAIL rand_status[%0d]: valid=%0b count=%0d ovf=%0b expected %0b/%0d/%0b",
                         n, out_valid, fifo_count, overflow_err, mq.size() > 0, mq.size(), ovf);
            end
            if (mq.size() > 0) begin
                vectors++;
                if ({out_propagate, out_data} !== {mq[0].p, mq[0].d}) begin
                    miscompares++;
                    $display("FAIL rand_head[%0d]: prop=%0b data=%0d expected %0b/%0d",
                             n, out_propagate, $signed(out_data), mq[0].p, $signed(mq[0].d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_rounding();
        test_saturation();
        test_carry_split();
        test_overflow();
        test_reset_midstream();
        test_full_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
